bla_subtractor: RTL and testbench
=================================

# bla_subtractor

Pipelined borrow-lookahead subtractor computing `diff = a - b - bin` over `SIZE` bits. It is split into `SIZE/SUBSIZE` groups, and each pipeline stage resolves one group with in-group lookahead; the borrow ripples stage to stage. It sits beside the carry-lookahead adder as its inverse arithmetic unit, serving datapaths that need subtraction and compare at high clock rate with valid/ready flow control.

## Interface
- `SIZE`, 16, operand width; must be a multiple of `SUBSIZE`.
- `SUBSIZE`, 4, group width; bits resolved per stage.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operands are presented.
- `in_ready` output 1: operands are accepted this cycle.
- `a` input [SIZE:1]: minuend.
- `b` input [SIZE:1]: subtrahend.
- `bin` input 1: borrow in.
- `out_valid` output 1: the result is presented.
- `out_ready` input 1: the consumer accepts the result.
- `diff` output [SIZE:1]: the result, modulo 2^SIZE.
- `bout` output 1: borrow out; 1 iff a < b + bin (unsigned).
- `ovf` output 1: signed overflow (only with `BLA_SUB_FLAGS_EN`).
- `zero` output 1: diff == 0 (only with `BLA_SUB_FLAGS_EN`).

## Operation
- Accept occurs when `in_valid && in_ready`. Deliver occurs when `out_valid && out_ready`.
- Pipeline: G = SIZE/SUBSIZE stages. Stage k (1..G) holds a valid bit, its borrow out, the finished diff groups 1..k, and skewed a/b groups k+1..G.
- Per bit:
  - borrow-generate = ~a & b
  - borrow-propagate = ~(a ^ b)
  - diff bit = a ^ b ^ borrow-in
- Within a group, the borrow into every bit comes from lookahead over generate/propagate. Bit 1 of group k takes the borrow from stage k-1; stage 1 takes `bin`.
- Stall is global. `stall = out_valid && !out_ready`. While stalled, no stage register changes.
- `in_ready = !stall`, i.e. `out_ready || !out_valid`. It is combinational and independent of `in_valid`.
- When not stalled, every stage advances. Stage 1's valid bit loads from `in_valid`; bubbles propagate as invalid.
- Results emerge strictly in acceptance order. Nothing is dropped or duplicated.
- `diff`, `bout` and the flags come straight from stage-G registers. They are held stable while `out_valid && !out_ready`.
- Arithmetic is modulo 2^SIZE and the operands are not extended. `ovf = (a[SIZE] != b[SIZE]) && (diff[SIZE] != a[SIZE])`, which requires the operand MSBs to be carried to stage G.

## Timing
- Latency: G cycles from an accepting edge to `out_valid`. For 16/4 this is 4 cycles.
- Throughput: one result per cycle when `out_ready` stays high.
- Reset: all valid bits clear, so `out_valid=0`. `diff`, `bout`, `ovf` and `zero` are all 0. `in_ready=1` once reset is released.
- Reset mid-operation: all in-flight operations are discarded, with no partial output.
- Simultaneous accept and deliver while full is legal and is the steady-state case.
- Deasserting `out_ready` freezes the pipe in the same cycle: `in_ready` falls combinationally and no accept occurs.
- SIZE == SUBSIZE degenerates to a single registered stage with latency 1.

## Configuration
- `BLA_SUB_FLAGS_EN` defined: the `ovf` and `zero` ports exist. `zero` is computed in stage G from the final diff register, with no extra latency.
- `BLA_SUB_FLAGS_EN` undefined: the `ovf` and `zero` ports and their logic and registers are absent. Everything else is identical.

## Structure
- Package `bla_pkg` holds:
  - the default `SIZE` and `SUBSIZE` constants;
  - the group-count function (SIZE/SUBSIZE, with an elaboration-time check that SIZE % SUBSIZE == 0);
  - the per-stage struct typedef: valid bit, borrow, diff-so-far and skewed operands.
- Sub-module `bla_group_stage`: the combinational lookahead for one `SUBSIZE` group (g/p inputs, borrow in, diff group and borrow out). It is instantiated once per stage. The top level owns all registers and the stall logic.

## Test plan
All cases use SIZE=16, SUBSIZE=4 with flags enabled.
- Basic subtraction: a=0x1234, b=0x0234, bin=0 → four cycles later diff=0x1000, bout=0, ovf=0, zero=0.
- Underflow: a=0x0000, b=0x0001, bin=0 → diff=0xFFFF, bout=1. Also a=0x0005, b=0x0005, bin=1 → diff=0xFFFF, bout=1.
- Zero and signed overflow:
  - a=0x00AB, b=0x00AB, bin=0 → zero=1, bout=0.
  - a=0x8000, b=0x0001 → diff=0x7FFF, ovf=1.
  - a=0x7FFF, b=0xFFFF → diff=0x8000, ovf=1.
- Backpressure: stream 8 random operands back-to-back while holding `out_ready` low for cycles 5–9 → `in_ready` low in exactly those cycles, outputs held stable, all 8 results correct and in order.
- Reset mid-flight: accept 3 operands, then pulse `rst_n` low asynchronously mid-cycle → `out_valid` drops immediately, outputs read 0, and no stale result appears after release.
- Bubbles: `in_valid` pattern 1,0,1,0 → the `out_valid` pattern reproduces it exactly 4 cycles later.

Source files
------------

// File: rtl/bla_pkg.sv
// Shared constants, group-count helper and per-stage record for the borrow-lookahead subtractor.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package bla_pkg;

    localparam int BLA_SIZE     = 16;
    localparam int BLA_SUBSIZE  = 4;
    // Widest operand a stage record can carry; narrower builds leave the top bits at zero.
    localparam int BLA_MAX_SIZE = 64;

    // One pipeline stage: valid, borrow leaving the last resolved group, diff groups
    // resolved so far, and the operands still waiting to be resolved further down.
    typedef struct packed {
        logic                    vld;
        logic                    brw;
        logic [BLA_MAX_SIZE:1]   dif;
        logic [BLA_MAX_SIZE:1]   opa;
        logic [BLA_MAX_SIZE:1]   opb;
    } bla_stage_t;

    function automatic int bla_groups(input int size, input int subsize);
        return size / subsize;
    endfunction

    // Used at elaboration to reject widths that do not split evenly or overflow the record.
    function automatic bit bla_cfg_ok(input int size, input int subsize);
        return (subsize > 0) && (size >= subsize) && (size % subsize == 0) &&
               (size <= BLA_MAX_SIZE);
    endfunction

endpackage

// File: rtl/bla_group_stage.sv
// Combinational borrow lookahead across one SUBSIZE-bit group of a subtraction.
// Latency: 0 cycles (pure logic, registered by the caller).
// Backpressure: none; caller owns all state and stalling.
// Ports: g/p per-bit borrow generate/propagate, bin borrow into bit 1,
//        diff resolved group bits, bout borrow out of the top bit.
module bla_group_stage #(
    parameter int SUBSIZE = 4
) (
    input  logic [SUBSIZE:1] g,
    input  logic [SUBSIZE:1] p,
    input  logic             bin,
    output logic [SUBSIZE:1] diff,
    output logic             bout
);

    logic [SUBSIZE+1:1] brw;
    logic               term;

    // Borrow into bit i as a flat sum of products: bin propagated through every
    // lower bit, OR any lower generate propagated through the bits above it.
    always_comb begin
        brw  = '0;
        term = 1'b0;
        for (int i = 1; i <= SUBSIZE + 1; i++) begin
            term = bin;
            for (int j = 1; j < i; j++) begin
                term = term & p[j];
            end
            brw[i] = term;
            for (int j = 1; j < i; j++) begin
                term = g[j];
                for (int m = j + 1; m < i; m++) begin
                    term = term & p[m];
                end
                brw[i] = brw[i] | term;
            end
        end
    end

    // a ^ b is the inverse of propagate, so diff = ~p ^ borrow-in.
    always_comb begin
        diff = '0;
        for (int i = 1; i <= SUBSIZE; i++) begin
            diff[i] = ~p[i] ^ brw[i];
        end
    end

    assign bout = brw[SUBSIZE+1];

endmodule

// File: rtl/bla_subtractor.sv
// Pipelined borrow-lookahead subtractor, diff = a - b - bin, one SUBSIZE group per stage.
// Latency: SIZE/SUBSIZE cycles from accept to out_valid; one result per cycle sustained.
// Backpressure: global stall when out_valid && !out_ready; in_ready = !stall, whole pipe freezes.
// Ports: clk, rst_n (async active-low); in_valid/in_ready with a, b, bin;
//        out_valid/out_ready with diff, bout; ovf and zero only when BLA_SUB_FLAGS_EN is defined.
module bla_subtractor
    import bla_pkg::*;
#(
    parameter int SIZE    = BLA_SIZE,
    parameter int SUBSIZE = BLA_SUBSIZE
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [SIZE:1] a,
    input  logic [SIZE:1] b,
    input  logic          bin,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [SIZE:1] diff,
    output logic          bout
`ifdef BLA_SUB_FLAGS_EN
    ,
    output logic          ovf,
    output logic          zero
`endif
);

    localparam int G = bla_groups(SIZE, SUBSIZE);

    if (!bla_cfg_ok(SIZE, SUBSIZE)) begin : g_cfg_err
        $error("bla_subtractor: SIZE must be a multiple of SUBSIZE and at most BLA_MAX_SIZE");
    end

    bla_stage_t       src0;
    bla_stage_t       prev_w   [1:G];
    bla_stage_t       stage_d  [1:G];
    bla_stage_t       stage_q  [1:G];
    logic [SUBSIZE:1] grp_g    [1:G];
    logic [SUBSIZE:1] grp_p    [1:G];
    logic [SUBSIZE:1] grp_dif  [1:G];
    logic             grp_bin  [1:G];
    logic             grp_bout [1:G];
    logic             stall;

    assign stall    = stage_q[G].vld & ~out_ready;
    assign in_ready = ~stall;

    // Incoming operands packaged as a virtual stage 0.
    always_comb begin
        src0              = '0;
        src0.vld          = in_valid;
        src0.brw          = bin;
        src0.opa[SIZE:1]  = a;
        src0.opb[SIZE:1]  = b;
    end

    for (genvar k = 1; k <= G; k++) begin : g_stage
        localparam int LO = (k - 1) * SUBSIZE + 1;
        localparam int HI = k * SUBSIZE;

        if (k == 1) begin : g_first
            assign prev_w[k] = src0;
        end else begin : g_next
            assign prev_w[k] = stage_q[k-1];
        end

        assign grp_g[k]   = ~prev_w[k].opa[HI:LO] & prev_w[k].opb[HI:LO];
        assign grp_p[k]   = ~(prev_w[k].opa[HI:LO] ^ prev_w[k].opb[HI:LO]);
        assign grp_bin[k] = prev_w[k].brw;

        bla_group_stage #(
            .SUBSIZE (SUBSIZE)
        ) u_grp (
            .g    (grp_g[k]),
            .p    (grp_p[k]),
            .bin  (grp_bin[k]),
            .diff (grp_dif[k]),
            .bout (grp_bout[k])
        );
    end

    // Each stage takes the previous record, fills in its own diff group and
    // replaces the borrow; operands ride along so the MSBs reach the last stage.
    always_comb begin
        for (int k = 1; k <= G; k++) begin
            stage_d[k]     = prev_w[k];
            stage_d[k].brw = grp_bout[k];
            stage_d[k].dif[(k-1)*SUBSIZE+1 +: SUBSIZE] = grp_dif[k];
            if (stall) begin
                stage_d[k] = stage_q[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= G; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            for (int k = 1; k <= G; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    assign out_valid = stage_q[G].vld;
    assign diff      = stage_q[G].dif[SIZE:1];
    assign bout      = stage_q[G].brw;

`ifdef BLA_SUB_FLAGS_EN
    logic ovf_d;
    logic ovf_q;
    logic zero_d;
    logic zero_q;

    // Flags load together with the final stage so they add no latency; when
    // stalled stage_d[G] is the held record, so the flags hold as well.
    always_comb begin
        ovf_d  = stage_d[G].vld &
                 (stage_d[G].opa[SIZE] != stage_d[G].opb[SIZE]) &
                 (stage_d[G].dif[SIZE] != stage_d[G].opa[SIZE]);
        zero_d = stage_d[G].vld & (stage_d[G].dif[SIZE:1] == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign ovf  = ovf_q;
    assign zero = zero_q;
`endif

endmodule

// File: tb/tb_bla_subtractor.sv
// Self-checking bench for bla_subtractor (16-bit, 4-bit groups) against a plain arithmetic model.
// Latency: checks 4-cycle accept-to-valid on unstalled traffic.
// Backpressure: exercises stalls, bubbles, async reset mid-flight and random ready/valid.
module tb_bla_subtractor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [16:1] a;
    logic [16:1] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [16:1] diff;
    logic        bout;
`ifdef BLA_SUB_FLAGS_EN
    logic        ovf;
    logic        zero;
`endif

    always #5 clk = ~clk;

    bla_subtractor #(
        .SIZE    (16),
        .SUBSIZE (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
`ifdef BLA_SUB_FLAGS_EN
        ,
        .ovf       (ovf),
        .zero      (zero)
`endif
    );

    typedef struct {
        logic [15:0] d;
        logic        bo;
        logic        ov;
        logic        z;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;
    int   delivered = 0;
    bit   lat_en    = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Reference: integer subtraction, borrow from the sign of the wide result,
    // overflow from the true signed result leaving the 16-bit range.
    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                   input logic c, input int acc);
        exp_t e;
        int   xu;
        int   yu;
        int   xs;
        int   ys;
        int   r;
        int   sr;
        xu    = x;
        yu    = y;
        xs    = $signed(x);
        ys    = $signed(y);
        r     = xu - yu - (c ? 1 : 0);
        sr    = xs - ys - (c ? 1 : 0);
        e.d   = r[15:0];
        e.bo  = (r < 0);
        e.ov  = (sr < -32768) || (sr > 32767);
        e.z   = (e.d == 16'h0000);
        e.acc = acc;
        return e;
    endfunction

    // One clock: drive, sample before the edge, score deliveries/accepts, advance.
    task automatic cycle(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                         input logic ibin, input logic ordy,
                         output logic s_ov, output logic s_ir);
        in_valid  = iv;
        a         = ia;
        b         = ib;
        bin       = ibin;
        out_ready = ordy;
        #1;
        s_ov = out_valid;
        s_ir = in_ready;
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_valid", 32'(out_valid), 32'd0);
            end else begin
                chk("diff", 32'(diff), 32'(q[0].d));
                chk("bout", 32'(bout), 32'(q[0].bo));
`ifdef BLA_SUB_FLAGS_EN
                chk("ovf", 32'(ovf), 32'(q[0].ov));
                chk("zero", 32'(zero), 32'(q[0].z));
`endif
                if (ordy) begin
                    if (lat_en) chk("latency", 32'(cyc - q[0].acc), 32'd4);
                    void'(q.pop_front());
                    delivered++;
                end
            end
        end
        if (iv && in_ready) q.push_back(model(ia, ib, ibin, cyc));
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_single(input logic [15:0] x, input logic [15:0] y, input logic c);
        logic ov;
        logic ir;
        int   n;
        lat_en = 1'b1;
        cycle(1'b1, x, y, c, 1'b1, ov, ir);
        n = 0;
        while (q.size() != 0 && n < 10) begin
            cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, ov, ir);
            n++;
        end
        chk("single_drain", 32'(q.size()), 32'd0);
        lat_en = 1'b0;
    endtask

    initial begin
        logic s_ov;
        logic s_ir;
        logic pat  [4];
        logic seen [12];
        int   acc_n;
        int   vcount;
        int   n;
        int   d0;
        logic iv;
        logic ordy;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        out_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
`ifdef BLA_SUB_FLAGS_EN
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed arithmetic cases
        run_single(16'h1234, 16'h0234, 1'b0);
        run_single(16'h0000, 16'h0001, 1'b0);
        run_single(16'h0005, 16'h0005, 1'b1);
        run_single(16'h00AB, 16'h00AB, 1'b0);
        run_single(16'h8000, 16'h0001, 1'b0);
        run_single(16'h7FFF, 16'hFFFF, 1'b0);
        run_single(16'hFFFF, 16'h0000, 1'b1);
        run_single(16'h0000, 16'hFFFF, 1'b1);

        // Bubbles: valid pattern reappears four cycles later
        pat = '{1'b1, 1'b0, 1'b1, 1'b0};
        lat_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cycle((i < 4) ? pat[i] : 1'b0, 16'($urandom), 16'($urandom), 1'($urandom),
                  1'b1, seen[i], s_ir);
        end
        lat_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("bubble_lead", 32'(seen[i]), 32'd0);
            chk("bubble_pat", 32'(seen[i+4]), 32'(pat[i]));
            chk("bubble_tail", 32'(seen[i+8]), 32'd0);
        end

        // Backpressure: out_ready low in cycles 5..9 of a back-to-back stream
        acc_n = 0;
        d0    = delivered;
        for (int c = 1; c <= 30 && (acc_n < 8 || q.size() != 0); c++) begin
            iv   = (acc_n < 8);
            ordy = !(c >= 5 && c <= 9);
            cycle(iv, 16'($urandom), 16'($urandom), 1'($urandom), ordy, s_ov, s_ir);
            if (c <= 14) chk("bp_in_ready", 32'(s_ir), 32'(ordy));
            if (iv && s_ir) acc_n++;
        end
        chk("bp_accepted", 32'(acc_n), 32'd8);
        chk("bp_delivered", 32'(delivered - d0), 32'd8);
        chk("bp_drained", 32'(q.size()), 32'd0);

        // Reset mid-flight
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 16'($urandom) | 16'h0100, 16'($urandom) & 16'h00FF, 1'b0, 1'b1, s_ov, s_ir);
        end
        cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, s_ov, s_ir);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_diff", 32'(diff), 32'd0);
        chk("midrst_bout", 32'(bout), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
`ifdef BLA_SUB_FLAGS_EN
        chk("midrst_ovf", 32'(ovf), 32'd0);
        chk("midrst_zero", 32'(zero), 32'd0);
`endif
        q.delete();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vcount = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, s_ov, s_ir);
            if (s_ov) vcount++;
        end
        chk("post_rst_no_stale", 32'(vcount), 32'd0);

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom), 1'($urandom),
                  $urandom_range(0, 3) != 0, s_ov, s_ir);
        end
        n = 0;
        while (q.size() != 0 && n < 40) begin
            cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, s_ov, s_ir);
            n++;
        end
        chk("rand_drained", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
